s2p_converter: RTL and testbench
================================

S2P_CONVERTER -- requirements
Module: s2p_converter

Interface
REQ-001 SHALL have parameter OUT_WIDTH, default 4, giving the parallel word width in bits; legal range 2..32.
REQ-002 SHALL have localparameter CNT_WIDTH = $clog2(OUT_WIDTH)+1, the bit-counter width.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port serialIn, input, 1 bit: serial data bit, sampled on each rising CLK edge while start=1.
REQ-006 SHALL have port start, input, 1 bit: level enable; 1 means conversion is active, 0 means abort and idle.
REQ-007 SHALL have port parallelOut, output, OUT_WIDTH bits: last completed word, registered.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking a new parallelOut word, registered.

Function
REQ-009 SHALL implement a two-state FSM with states IDLE and SHIFT.
- IDLE->SHIFT on an edge with start=1.
- SHIFT->IDLE on an edge with start=0.
REQ-010 SHALL sample serialIn on every rising edge where start=1 and RST=0, including the IDLE->SHIFT edge, so there are no dead cycles.
REQ-011 SHALL shift MSB-first: the first bit of a word ends in parallelOut[OUT_WIDTH-1] and the last in parallelOut[0].
REQ-012 SHALL hold the count of bits received in the current word (0..OUT_WIDTH-1) and increment it on each sample.
REQ-013 On the edge that samples bit number OUT_WIDTH, SHALL:
- load parallelOut <= {shift_reg[OUT_WIDTH-2:0], serialIn};
- set done=1 for exactly the following cycle;
- reset count to 0.
REQ-014 SHALL accept back-to-back words with no gap: the next edge after a completion samples bit 1 of the next word.
REQ-015 SHALL hold parallelOut unchanged between completions; done SHALL be 0 on every edge that does not complete a word.
REQ-016 On an edge with start=0, SHALL discard the partial word: count <= 0, shift register <= 0, done <= 0, with parallelOut unchanged.
REQ-017 If start falls on the same edge the last bit would complete, that bit SHALL NOT be sampled and no word SHALL be produced; start=0 always wins.
REQ-018 SHALL treat serialIn as don't-care while start=0.

Reset
REQ-019 On an edge with RST=1, SHALL set parallelOut=0, done=0, count=0, shift register=0 and state=IDLE, overriding start and serialIn.
REQ-020 On the first edge with RST=0 and start=1, SHALL sample bit 1 of a fresh word; reset during mid-word SHALL discard that word.

Structure
REQ-021 SHALL keep the FSM state encoding (IDLE, SHIFT) and the default width constant in a shared package, s2p_pkg.
REQ-022 SHALL be a single module with no sub-modules; the shift register, counter and FSM are separate always blocks.

Verification
REQ-023 SHALL verify reset: hold RST=1 with start=1 and serialIn=1 for 3 edges -> parallelOut=0000 and done=0 throughout.
REQ-024 SHALL verify back-to-back words: after reset, start=1 with serial bits 1,1,0,0,1,0,0,1,1,0,1,0, one per edge ->
- parallelOut=1100 after edge 4, 1001 after edge 8, 1010 after edge 12;
- done high only in the cycles after edges 4, 8 and 12.
REQ-025 SHALL verify a zero word: start=1 with serialIn=0 for 8 edges after 1010 -> parallelOut=0000 after edge 4, done pulses twice.
REQ-026 SHALL verify abort: bits 1,1 then start=0 for 2 edges, then start=1 with bits 0,1,1,0 -> parallelOut=0110 (no 11xx), done only after the final edge.
REQ-027 SHALL verify mid-word reset: bits 1,0,1, RST=1 for 1 edge, then bits 0,0,1,1 -> parallelOut=0011.
REQ-028 SHALL verify a wider instance: OUT_WIDTH=8 with bits 1,0,1,1,0,0,1,0 -> parallelOut=8'hB2 with one done pulse.

Source files
------------

// File: rtl/s2p_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : s2p_pkg
//  Description : Shared FSM state encoding and default word width for the
//                serial-to-parallel converter.
//  Revision    : 1.0 - initial release
// ============================================================================
package s2p_pkg;

    localparam int c_default_width = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } s2p_state_t;

endpackage : s2p_pkg
`default_nettype wire

// File: rtl/s2p_converter_if.sv
`default_nettype none
// ============================================================================
//  Module      : s2p_converter_if
//  Description : Serial input / parallel output bundle for s2p_converter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface s2p_converter_if
    import s2p_pkg::*;
#(
    parameter int OUT_WIDTH = c_default_width
);
    logic                 serialIn;
    logic                 start;
    logic [OUT_WIDTH-1:0] parallelOut;
    logic                 done;

    // Master drives the serial stream; the converter is the slave.
    modport master (
        output serialIn,
        output start,
        input  parallelOut,
        input  done
    );

    modport slave (
        input  serialIn,
        input  start,
        output parallelOut,
        output done
    );
endinterface : s2p_converter_if
`default_nettype wire

// File: rtl/s2p_converter.sv
`default_nettype none
// ============================================================================
//  Module      : s2p_converter
//  Description : MSB-first serial-to-parallel converter with a one-cycle done
//                pulse per completed word; start=0 aborts the partial word.
//  Revision    : 1.0 - initial release
// ============================================================================
module s2p_converter
    import s2p_pkg::*;
#(
    parameter int OUT_WIDTH = c_default_width
) (
    input  wire logic          CLK,
    input  wire logic          RST,
    s2p_converter_if.slave     bus
);

    localparam int CNT_WIDTH = $clog2(OUT_WIDTH) + 1;

    s2p_state_t             r_state;
    s2p_state_t             w_next_state;
    logic [CNT_WIDTH-1:0]   r_count;
    logic [OUT_WIDTH-2:0]   r_shift;
    logic [OUT_WIDTH-1:0]   w_shift_next;
    logic [OUT_WIDTH-1:0]   r_parallel;
    logic                   r_done;
    logic                   w_last;

    // Sampling depends only on start, so the IDLE->SHIFT edge already
    // captures bit 1 and abort (start=0) always beats completion.
    assign w_shift_next = {r_shift, bus.serialIn};
    assign w_last       = bus.start && (r_count == CNT_WIDTH'(OUT_WIDTH - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.start)  w_next_state = SHIFT;
            SHIFT:   if (!bus.start) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST || !bus.start) begin
            r_count <= '0;
        end else if (w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || !bus.start) begin
            r_shift <= '0;
        end else begin
            r_shift <= w_shift_next[OUT_WIDTH-2:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_parallel <= '0;
            r_done     <= 1'b0;
        end else if (w_last) begin
            r_parallel <= w_shift_next;
            r_done     <= 1'b1;
        end else begin
            r_done     <= 1'b0;
        end
    end

    assign bus.parallelOut = r_parallel;
    assign bus.done        = r_done;

endmodule : s2p_converter
`default_nettype wire

// File: tb/tb_s2p_converter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_s2p_converter
//  Description : Self-checking bench for s2p_converter (4-bit and 8-bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_s2p_converter;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    s2p_converter_if #(.OUT_WIDTH(4)) bus4 ();
    s2p_converter_if #(.OUT_WIDTH(8)) bus8 ();

    s2p_converter #(.OUT_WIDTH(4)) u_dut4 (.CLK(CLK), .RST(RST), .bus(bus4));
    s2p_converter #(.OUT_WIDTH(8)) u_dut8 (.CLK(CLK), .RST(RST), .bus(bus8));

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] exp_q  [$];
    logic [7:0] exp8_q [$];

    // Reference model of the 4-bit converter
    int         m_cnt   = 0;
    logic [3:0] m_shift = '0;
    logic [3:0] m_par   = '0;
    logic       m_done  = 1'b0;

    task automatic step4(input logic rst_v, input logic start_v, input logic bit_v);
        RST           = rst_v;
        bus4.start    = start_v;
        bus4.serialIn = bit_v;
        bus8.start    = 1'b0;
        bus8.serialIn = 1'b0;
        if (rst_v) begin
            m_cnt = 0; m_shift = '0; m_par = '0; m_done = 1'b0;
        end else if (!start_v) begin
            m_cnt = 0; m_shift = '0; m_done = 1'b0;
        end else begin
            m_shift = {m_shift[2:0], bit_v};
            if (m_cnt == 3) begin
                m_par  = m_shift;
                m_done = 1'b1;
                m_cnt  = 0;
                exp_q.push_back(m_shift);
            end else begin
                m_done = 1'b0;
                m_cnt  = m_cnt + 1;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic step8(input logic start_v, input logic bit_v);
        RST           = 1'b0;
        bus4.start    = 1'b0;
        bus4.serialIn = 1'b0;
        bus8.start    = start_v;
        bus8.serialIn = bit_v;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step4(1'b1, 1'b1, 1'b1);
            n_checks++;
            if (bus4.parallelOut !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_out edge %0d: got %b, expected 0000", i + 1, bus4.parallelOut);
            end
            n_checks++;
            if (bus4.done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_done edge %0d: got %b, expected 0", i + 1, bus4.done);
            end
        end
        n_checks++;
        if (bus8.parallelOut !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_out8: got %h, expected 00", bus8.parallelOut);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] bits;
        logic [3:0]  words [3];
        logic [3:0]  e;
        bits  = 12'b1100_1001_1010;
        words = '{4'b1100, 4'b1001, 4'b1010};
        for (int i = 0; i < 12; i++) begin
            step4(1'b0, 1'b1, bits[11-i]);
            n_checks++;
            if (bus4.done !== ((i % 4) == 3)) begin
                n_fail++;
                $display("FAIL b2b_done edge %0d: got %b, expected %b", i + 1, bus4.done, ((i % 4) == 3));
            end
            if ((i % 4) == 3) begin
                n_checks++;
                if (bus4.parallelOut !== words[i/4]) begin
                    n_fail++;
                    $display("FAIL b2b_word edge %0d: got %b, expected %b", i + 1, bus4.parallelOut, words[i/4]);
                end
            end
            if (bus4.done === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_sb edge %0d: got unexpected done, expected none", i + 1);
                end else begin
                    e = exp_q.pop_front();
                    if (bus4.parallelOut !== e) begin
                        n_fail++;
                        $display("FAIL b2b_sb edge %0d: got %b, expected %b", i + 1, bus4.parallelOut, e);
                    end
                end
            end
        end
    endtask

    task automatic test_zero_word();
        int         pulses;
        logic [3:0] e;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step4(1'b0, 1'b1, 1'b0);
            n_checks++;
            if (bus4.done !== m_done) begin
                n_fail++;
                $display("FAIL zero_done edge %0d: got %b, expected %b", i + 1, bus4.done, m_done);
            end
            if (i < 3) begin
                n_checks++;
                if (bus4.parallelOut !== 4'b1010) begin
                    n_fail++;
                    $display("FAIL zero_hold edge %0d: got %b, expected 1010", i + 1, bus4.parallelOut);
                end
            end
            if (i == 3) begin
                n_checks++;
                if (bus4.parallelOut !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL zero_word: got %b, expected 0000", bus4.parallelOut);
                end
            end
            if (bus4.done === 1'b1) begin
                pulses++;
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    n_checks++;
                    if (bus4.parallelOut !== e) begin
                        n_fail++;
                        $display("FAIL zero_sb edge %0d: got %b, expected %b", i + 1, bus4.parallelOut, e);
                    end
                end
            end
        end
        n_checks++;
        if (pulses != 2) begin
            n_fail++;
            $display("FAIL zero_pulses: got %0d, expected 2", pulses);
        end
    endtask

    task automatic test_abort();
        logic [2:0] seq [8];
        int         pulses;
        logic [3:0] e;
        // {start, serialIn, unused}: 1,1 then two abort edges, then 0,1,1,0
        seq = '{3'b110, 3'b110, 3'b000, 3'b000, 3'b100, 3'b110, 3'b110, 3'b100};
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            logic b;
            b = seq[i][2] ? seq[i][1] : 1'($urandom_range(1));
            step4(1'b0, seq[i][2], b);
            n_checks++;
            if (bus4.done !== (i == 7)) begin
                n_fail++;
                $display("FAIL abort_done edge %0d: got %b, expected %b", i + 1, bus4.done, (i == 7));
            end
            if (bus4.done === 1'b1) begin
                pulses++;
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    n_checks++;
                    if (bus4.parallelOut !== e) begin
                        n_fail++;
                        $display("FAIL abort_sb edge %0d: got %b, expected %b", i + 1, bus4.parallelOut, e);
                    end
                end
            end
        end
        n_checks++;
        if (bus4.parallelOut !== 4'b0110) begin
            n_fail++;
            $display("FAIL abort_word: got %b, expected 0110", bus4.parallelOut);
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL abort_pulses: got %0d, expected 1", pulses);
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0] tail;
        logic [3:0] e;
        step4(1'b0, 1'b1, 1'b1);
        step4(1'b0, 1'b1, 1'b0);
        step4(1'b0, 1'b1, 1'b1);
        step4(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (bus4.parallelOut !== 4'b0000 || bus4.done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_clear: got out=%b done=%b, expected out=0000 done=0", bus4.parallelOut, bus4.done);
        end
        tail = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            step4(1'b0, 1'b1, tail[3-i]);
            n_checks++;
            if (bus4.done !== (i == 3)) begin
                n_fail++;
                $display("FAIL midrst_done edge %0d: got %b, expected %b", i + 1, bus4.done, (i == 3));
            end
            if (bus4.done === 1'b1 && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (bus4.parallelOut !== e) begin
                    n_fail++;
                    $display("FAIL midrst_sb: got %b, expected %b", bus4.parallelOut, e);
                end
            end
        end
        n_checks++;
        if (bus4.parallelOut !== 4'b0011) begin
            n_fail++;
            $display("FAIL midrst_word: got %b, expected 0011", bus4.parallelOut);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d pending words, expected 0", exp_q.size());
        end
    endtask

    task automatic test_wide();
        logic [7:0] bits;
        logic [7:0] e;
        int         pulses;
        bits   = 8'b1011_0010;
        pulses = 0;
        exp8_q.push_back(8'hB2);
        for (int i = 0; i < 8; i++) begin
            step8(1'b1, bits[7-i]);
            n_checks++;
            if (bus8.done !== (i == 7)) begin
                n_fail++;
                $display("FAIL wide_done edge %0d: got %b, expected %b", i + 1, bus8.done, (i == 7));
            end
            if (bus8.done === 1'b1) begin
                pulses++;
                n_checks++;
                if (exp8_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL wide_sb: got unexpected done, expected none");
                end else begin
                    e = exp8_q.pop_front();
                    if (bus8.parallelOut !== e) begin
                        n_fail++;
                        $display("FAIL wide_sb: got %h, expected %h", bus8.parallelOut, e);
                    end
                end
            end
        end
        step8(1'b0, 1'b1);
        n_checks++;
        if (bus8.parallelOut !== 8'hB2 || bus8.done !== 1'b0) begin
            n_fail++;
            $display("FAIL wide_hold: got out=%h done=%b, expected out=b2 done=0", bus8.parallelOut, bus8.done);
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL wide_pulses: got %0d, expected 1", pulses);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, expected end of test");
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin
        RST           = 1'b1;
        bus4.start    = 1'b0;
        bus4.serialIn = 1'b0;
        bus8.start    = 1'b0;
        bus8.serialIn = 1'b0;
        @(posedge CLK);
        #1;
        test_reset();
        test_back_to_back();
        test_zero_word();
        test_abort();
        test_mid_reset();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_s2p_converter
`default_nettype wire
